// File: rtl/ecdsa_op_scheduler_if.sv
// Requester-side handshake bundle for ecdsa_op_scheduler: one sign port and one verify port.
interface ecdsa_op_scheduler_if #(
    parameter int unsigned KEY_SIZE = 64,
    parameter int unsigned WIDTH    = 32
);
    logic                s_req;
    logic [WIDTH-1:0]    s_hash;
    logic                s_ack;
    logic                s_done;
    logic [KEY_SIZE-1:0] s_r;
    logic [KEY_SIZE-1:0] s_s;
    logic                s_err;

    logic                v_req;
    logic [WIDTH-1:0]    v_hash;
    logic [KEY_SIZE-1:0] v_r;
    logic [KEY_SIZE-1:0] v_s;
    logic                v_ack;
    logic                v_done;
    logic                v_ok;
    logic                v_err;

    modport master (
        output s_req, s_hash, v_req, v_hash, v_r, v_s,
        input  s_ack, s_done, s_r, s_s, s_err, v_ack, v_done, v_ok, v_err
    );

    modport slave (
        input  s_req, s_hash, v_req, v_hash, v_r, v_s,
        output s_ack, s_done, s_r, s_s, s_err, v_ack, v_done, v_ok, v_err
    );
endinterface

// File: rtl/ecdsa_op_scheduler.sv
// Front-end controller for ecdsa_combined: key setup after reset, round-robin arbitration of
// sign/verify requests, one core operation at a time with a per-operation timeout.
module ecdsa_op_scheduler #(
    parameter int unsigned KEY_SIZE       = 64,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    ecdsa_op_scheduler_if.slave req,
    output logic                key_ready,
    output logic                key_err,
    output logic                ecc_go,
    output logic                sign_go,
    output logic                verify_go,
    output logic [WIDTH-1:0]    hashedMessage,
    output logic [KEY_SIZE-1:0] verifying_r,
    output logic [KEY_SIZE-1:0] verifying_s,
    input  logic                ecc_done,
    input  logic                sign_done,
    input  logic                verify_done,
    input  logic                sign_ready,
    input  logic                verify_ready,
    input  logic                verified,
    input  logic                failure,
    input  logic                infiityPPubKey,
    input  logic [KEY_SIZE-1:0] r_sign,
    input  logic [KEY_SIZE-1:0] s_sign
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        StSetup, StKeyWait, StIdle, StSRun, StVWaitRdy, StVRun, StFailResp, StResp, StKeyFail
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            prio_v_q;
    logic            serve_v_q;
    logic            grant_s;
    logic            grant_v;
    logic            timeout;
    logic            unused_inputs;

    // The core's sign path needs no readiness handshake.
    assign unused_inputs = sign_ready;

    // prio_v_q set means verify wins a tie; it always points away from the side last served.
    assign grant_s = req.s_req && (!req.v_req || !prio_v_q);
    assign grant_v = req.v_req && (!req.s_req || prio_v_q);
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StSetup;
            cnt_q         <= '0;
            prio_v_q      <= 1'b0;
            serve_v_q     <= 1'b0;
            key_ready     <= 1'b0;
            key_err       <= 1'b0;
            ecc_go        <= 1'b0;
            sign_go       <= 1'b0;
            verify_go     <= 1'b0;
            hashedMessage <= '0;
            verifying_r   <= '0;
            verifying_s   <= '0;
            req.s_ack     <= 1'b0;
            req.s_done    <= 1'b0;
            req.s_r       <= '0;
            req.s_s       <= '0;
            req.s_err     <= 1'b0;
            req.v_ack     <= 1'b0;
            req.v_done    <= 1'b0;
            req.v_ok      <= 1'b0;
            req.v_err     <= 1'b0;
        end else begin
            req.s_ack  <= 1'b0;
            req.v_ack  <= 1'b0;
            req.s_done <= 1'b0;
            req.v_done <= 1'b0;
            unique case (state_q)
                StSetup: begin
                    ecc_go  <= 1'b1;
                    state_q <= StKeyWait;
                end
                StKeyWait: begin
                    if (ecc_done) begin
                        ecc_go <= 1'b0;
                        if (infiityPPubKey) begin
                            key_err <= 1'b1;
                            state_q <= StKeyFail;
                        end else begin
                            key_ready <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                end
                StIdle, StKeyFail: begin
                    // Without a valid key the core is never started; requests fail immediately.
                    if (grant_s) begin
                        req.s_ack     <= 1'b1;
                        hashedMessage <= req.s_hash;
                        prio_v_q      <= 1'b1;
                        serve_v_q     <= 1'b0;
                        cnt_q         <= '0;
                        if (key_err) begin
                            state_q <= StFailResp;
                        end else begin
                            sign_go <= 1'b1;
                            state_q <= StSRun;
                        end
                    end else if (grant_v) begin
                        req.v_ack     <= 1'b1;
                        hashedMessage <= req.v_hash;
                        verifying_r   <= req.v_r;
                        verifying_s   <= req.v_s;
                        prio_v_q      <= 1'b0;
                        serve_v_q     <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= key_err ? StFailResp : StVWaitRdy;
                    end
                end
                StSRun: begin
                    if (sign_done) begin
                        sign_go    <= 1'b0;
                        req.s_r    <= r_sign;
                        req.s_s    <= s_sign;
                        req.s_err  <= failure;
                        req.s_done <= 1'b1;
                        state_q    <= StResp;
                    end else if (timeout) begin
                        sign_go    <= 1'b0;
                        req.s_r    <= '0;
                        req.s_s    <= '0;
                        req.s_err  <= 1'b1;
                        req.s_done <= 1'b1;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StVWaitRdy: begin
                    if (timeout) begin
                        req.v_ok   <= 1'b0;
                        req.v_err  <= 1'b1;
                        req.v_done <= 1'b1;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (verify_ready) begin
                            verify_go <= 1'b1;
                            state_q   <= StVRun;
                        end
                    end
                end
                StVRun: begin
                    if (verify_done) begin
                        verify_go  <= 1'b0;
                        req.v_ok   <= verified;
                        req.v_err  <= 1'b0;
                        req.v_done <= 1'b1;
                        state_q    <= StResp;
                    end else if (timeout) begin
                        verify_go  <= 1'b0;
                        req.v_ok   <= 1'b0;
                        req.v_err  <= 1'b1;
                        req.v_done <= 1'b1;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StFailResp: begin
                    if (serve_v_q) begin
                        req.v_ok   <= 1'b0;
                        req.v_err  <= 1'b1;
                        req.v_done <= 1'b1;
                    end else begin
                        req.s_r    <= '0;
                        req.s_s    <= '0;
                        req.s_err  <= 1'b1;
                        req.s_done <= 1'b1;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    state_q <= key_err ? StKeyFail : StIdle;
                end
                default: begin
                    state_q <= StSetup;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecdsa_op_scheduler.sv
// Scoreboard bench for ecdsa_op_scheduler with a toy behavioural core behind it.
`timescale 1ns/1ps
module tb_ecdsa_op_scheduler;
    localparam int unsigned KS = 64;
    localparam int unsigned W  = 32;
    localparam int unsigned TO = 16;

    typedef struct {
        logic [KS-1:0] r;
        logic [KS-1:0] s;
        logic          err;
    } s_exp_t;

    typedef struct {
        logic ok;
        logic err;
    } v_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ecdsa_op_scheduler_if #(.KEY_SIZE(KS), .WIDTH(W)) bus ();

    logic          key_ready, key_err, ecc_go, sign_go, verify_go;
    logic [W-1:0]  hashedMessage;
    logic [KS-1:0] verifying_r, verifying_s;
    logic          ecc_done = 1'b0, sign_done = 1'b0, verify_done = 1'b0;
    logic          sign_ready = 1'b1, verify_ready = 1'b0, verified = 1'b0;
    logic          failure = 1'b0, infiityPPubKey = 1'b0;
    logic [KS-1:0] r_sign = '0, s_sign = '0;

    ecdsa_op_scheduler #(.KEY_SIZE(KS), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (bus.slave),
        .key_ready      (key_ready),
        .key_err        (key_err),
        .ecc_go         (ecc_go),
        .sign_go        (sign_go),
        .verify_go      (verify_go),
        .hashedMessage  (hashedMessage),
        .verifying_r    (verifying_r),
        .verifying_s    (verifying_s),
        .ecc_done       (ecc_done),
        .sign_done      (sign_done),
        .verify_done    (verify_done),
        .sign_ready     (sign_ready),
        .verify_ready   (verify_ready),
        .verified       (verified),
        .failure        (failure),
        .infiityPPubKey (infiityPPubKey),
        .r_sign         (r_sign),
        .s_sign         (s_sign)
    );

    int     total = 0;
    int     bad = 0;
    bit     core_hang = 1'b0;
    bit     core_inf = 1'b0;
    s_exp_t s_q[$];
    v_exp_t v_q[$];
    bit     ack_log[$];
    int     ecc_rises = 0;
    int     sign_rises = 0;
    logic   ecc_prev = 1'b0;
    logic   sign_prev = 1'b0;

    // Toy signature scheme: the "core" signs as a fixed function of the hash.
    function automatic logic [KS-1:0] fn_r(input logic [W-1:0] h);
        return {h ^ 32'hA5A5_5A5A, ~h};
    endfunction

    function automatic logic [KS-1:0] fn_s(input logic [W-1:0] h);
        return {h * 32'd3, h ^ 32'hDEAD_BEEF};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural core: pulses done one cycle after a random latency.
    initial begin
        forever begin
            @(negedge clk);
            if (ecc_go) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                ecc_done = 1'b1;
                infiityPPubKey = core_inf;
                @(negedge clk);
                ecc_done = 1'b0;
                infiityPPubKey = 1'b0;
            end else if (sign_go) begin
                if (core_hang) begin
                    for (int i = 0; i < 200 && sign_go; i++) @(negedge clk);
                end else begin
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    r_sign = fn_r(hashedMessage);
                    s_sign = fn_s(hashedMessage);
                    failure = (hashedMessage[3:0] == 4'h0);
                    sign_done = 1'b1;
                    @(negedge clk);
                    sign_done = 1'b0;
                    failure = 1'b0;
                end
            end else if (verify_go) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                verified = (verifying_r == fn_r(hashedMessage)) &&
                           (verifying_s == fn_s(hashedMessage));
                verify_done = 1'b1;
                @(negedge clk);
                verify_done = 1'b0;
                verified = 1'b0;
            end else begin
                verify_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse, logs grants, checks go exclusivity.
    always @(negedge clk) begin
        if (bus.s_done) begin
            chk1("s_done_expected", s_q.size() != 0, 1'b1);
            if (s_q.size() != 0) begin
                s_exp_t e;
                e = s_q.pop_front();
                chk64("s_r", bus.s_r, e.r);
                chk64("s_s", bus.s_s, e.s);
                chk1("s_err", bus.s_err, e.err);
            end
        end
        if (bus.v_done) begin
            chk1("v_done_expected", v_q.size() != 0, 1'b1);
            if (v_q.size() != 0) begin
                v_exp_t e;
                e = v_q.pop_front();
                chk1("v_ok", bus.v_ok, e.ok);
                chk1("v_err", bus.v_err, e.err);
            end
        end
        if (bus.s_ack) ack_log.push_back(1'b0);
        if (bus.v_ack) ack_log.push_back(1'b1);
        if (ecc_go || sign_go || verify_go) begin
            chk1("one_go", (int'(ecc_go) + int'(sign_go) + int'(verify_go)) > 1, 1'b0);
        end
        if (ecc_go && !ecc_prev) ecc_rises++;
        if (sign_go && !sign_prev) sign_rises++;
        ecc_prev = ecc_go;
        sign_prev = sign_go;
    end

    task automatic sign_req(input logic [W-1:0] h);
        s_exp_t e;
        bit     got;
        if (core_inf || core_hang) begin
            e.r = '0;
            e.s = '0;
            e.err = 1'b1;
        end else begin
            e.r = fn_r(h);
            e.s = fn_s(h);
            e.err = (h[3:0] == 4'h0);
        end
        s_q.push_back(e);
        bus.s_req = 1'b1;
        bus.s_hash = h;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.s_ack) begin
                got = 1'b1;
                break;
            end
        end
        bus.s_req = 1'b0;
        bus.s_hash = $urandom();
        chk1("s_ack_seen", got, 1'b1);
    endtask

    task automatic verify_req(input logic [W-1:0] h, input logic [KS-1:0] r,
                              input logic [KS-1:0] s);
        v_exp_t e;
        bit     got;
        e.ok = !core_inf && (r == fn_r(h)) && (s == fn_s(h));
        e.err = core_inf;
        v_q.push_back(e);
        bus.v_req = 1'b1;
        bus.v_hash = h;
        bus.v_r = r;
        bus.v_s = s;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.v_ack) begin
                got = 1'b1;
                break;
            end
        end
        bus.v_req = 1'b0;
        bus.v_hash = $urandom();
        bus.v_r = {$urandom(), $urandom()};
        bus.v_s = {$urandom(), $urandom()};
        chk1("v_ack_seen", got, 1'b1);
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (s_q.size() == 0 && v_q.size() == 0) begin
                empty = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk1("drain", empty, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_key();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_ready || key_err) begin
                seen = 1'b1;
                break;
            end
        end
        chk1("key_wait", seen, 1'b1);
    endtask

    initial begin
        int   n;
        bit   seen;
        logic exp_pat [4];
        logic [W-1:0] h;

        bus.s_req = 1'b0;
        bus.s_hash = '0;
        bus.v_req = 1'b0;
        bus.v_hash = '0;
        bus.v_r = '0;
        bus.v_s = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk1("rst_ecc_go", ecc_go, 1'b0);
        chk1("rst_sign_go", sign_go, 1'b0);
        chk1("rst_verify_go", verify_go, 1'b0);
        chk1("rst_key_ready", key_ready, 1'b0);
        chk1("rst_key_err", key_err, 1'b0);
        chk1("rst_s_ack", bus.s_ack, 1'b0);
        chk1("rst_v_done", bus.v_done, 1'b0);
        chk64("rst_hash", 64'(hashedMessage), 64'd0);

        // Key setup
        rst = 1'b1;
        wait_key();
        chk1("setup_key_ready", key_ready, 1'b1);
        chk1("setup_key_err", key_err, 1'b0);
        chk1("setup_ecc_go_low", ecc_go, 1'b0);
        chk64("setup_ecc_rises", 64'(ecc_rises), 64'd1);

        // Sign then verify with its result; then an invalid signature
        sign_req(32'd1);
        drain();
        verify_req(32'd1, fn_r(32'd1), fn_s(32'd1));
        verify_req(32'd1, 64'd1, 64'd2);
        drain();

        // Randomized concurrent traffic on both ports
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    sign_req($urandom());
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    h = $urandom();
                    if ($urandom_range(0, 1) == 1) verify_req(h, fn_r(h), fn_s(h));
                    else verify_req(h, {$urandom(), $urandom()}, {$urandom(), $urandom()});
                end
            end
        join
        drain();

        // Arbitration: after a verify grant, simultaneous requests go S,V,S,V
        verify_req(32'h55, fn_r(32'h55), fn_s(32'h55));
        drain();
        ack_log.delete();
        fork
            begin
                sign_req(32'h1001);
                sign_req(32'h2002);
            end
            begin
                verify_req(32'h3003, fn_r(32'h3003), fn_s(32'h3003));
                verify_req(32'h4004, 64'd7, 64'd9);
            end
        join
        drain();
        exp_pat[0] = 1'b0;
        exp_pat[1] = 1'b1;
        exp_pat[2] = 1'b0;
        exp_pat[3] = 1'b1;
        chk64("arb_count", 64'(ack_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) chk1("arb_order", ack_log[i], exp_pat[i]);

        // Timeout: core never finishes the sign
        core_hang = 1'b1;
        sign_req(32'h77);
        chk1("to_go_high", sign_go, 1'b1);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (bus.s_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk1("to_done_seen", seen, 1'b1);
        chk64("to_latency", 64'(n), 64'(TO));
        chk1("to_go_dropped", sign_go, 1'b0);
        core_hang = 1'b0;
        drain();
        verify_req(32'h88, fn_r(32'h88), fn_s(32'h88));
        drain();

        // Key failure: requests answered with errors, core never started
        core_inf = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_key();
        chk1("kf_key_err", key_err, 1'b1);
        chk1("kf_key_ready", key_ready, 1'b0);
        n = sign_rises;
        sign_req(32'h99);
        @(negedge clk);
        chk1("kf_done_next", bus.s_done, 1'b1);
        drain();
        verify_req(32'h9A, fn_r(32'h9A), fn_s(32'h9A));
        drain();
        chk64("kf_no_sign_go", 64'(sign_rises), 64'(n));

        // Reset asserted while a verify is running
        core_inf = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_key();
        chk1("rs_key_ready", key_ready, 1'b1);
        bus.v_req = 1'b1;
        bus.v_hash = 32'h123;
        bus.v_r = fn_r(32'h123);
        bus.v_s = fn_s(32'h123);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.v_ack) bus.v_req = 1'b0;
            if (verify_go) begin
                seen = 1'b1;
                break;
            end
        end
        bus.v_req = 1'b0;
        chk1("rs_vrun_reached", seen, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("rs_verify_go", verify_go, 1'b0);
        chk1("rs_ecc_go", ecc_go, 1'b0);
        chk1("rs_key_ready_low", key_ready, 1'b0);
        chk1("rs_v_done", bus.v_done, 1'b0);
        chk64("rs_hash", 64'(hashedMessage), 64'd0);
        chk64("rs_verifying_r", verifying_r, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        n = ecc_rises;
        wait_key();
        chk1("rs_setup_again", key_ready, 1'b1);
        chk64("rs_ecc_rerun", 64'(ecc_rises), 64'(n + 1));
        verify_req(32'h456, fn_r(32'h456), fn_s(32'h456));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end
endmodule
